// File: rtl/nand_cpu_pkg.sv
// Shared types and sizing for the NAND CPU operand-issue path.
// ALU opcodes, register-file geometry and the decoded-instruction record.
package nand_cpu_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int IMM_W     = 6;

  typedef enum logic [2:0] {
    ALU_CL   = 3'd0,
    ALU_CP   = 3'd1,
    ALU_NAND = 3'd2,
    ALU_LS   = 3'd3,
    ALU_RS   = 3'd4,
    ALU_EQ   = 3'd5,
    ALU_NE   = 3'd6,
    ALU_LI   = 3'd7
  } ALU_OP;

  typedef struct packed {
    ALU_OP                op;
    logic [REG_IDX_W-1:0] rs0;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rd;
    logic                 use_imm;
    logic [IMM_W-1:0]     imm;
  } issue_t;

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

  function automatic logic is_binary(input ALU_OP op);
    return (op == ALU_NAND) || (op == ALU_LS) || (op == ALU_RS) ||
           (op == ALU_EQ)   || (op == ALU_NE);
  endfunction

endpackage

// File: rtl/alu_input_ifc.sv
// Operand bundle presented to the ALU: two data operands plus the opcode.
// The issue stage drives it through the out modport; the ALU reads through alu.
interface alu_input_ifc
  import nand_cpu_pkg::*;
  ();

  logic [DATA_W-1:0] op0;
  logic [DATA_W-1:0] op1;
  ALU_OP             alu_op;

  modport out (output op0, output op1, output alu_op);
  modport alu (input  op0, input  op1, input  alu_op);

endinterface

// File: rtl/nand_regfile.sv
// Architectural register file: three read ports, one write port, reset to zero.
// Reads see a same-cycle write to the same index, so callers never get stale data.
module nand_regfile
  import nand_cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] i_rs0_idx,
  input  logic [REG_IDX_W-1:0] i_rs1_idx,
  input  logic [REG_IDX_W-1:0] i_rd_idx,
  output logic [DATA_W-1:0]    o_rs0_data,
  output logic [DATA_W-1:0]    o_rs1_data,
  output logic [DATA_W-1:0]    o_rd_data,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_wa,
  input  logic [DATA_W-1:0]    i_wd
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  logic w_hit_rs0, w_hit_rs1, w_hit_rd;

  assign w_hit_rs0 = i_we && (i_wa == i_rs0_idx);
  assign w_hit_rs1 = i_we && (i_wa == i_rs1_idx);
  assign w_hit_rd  = i_we && (i_wa == i_rd_idx);

  assign o_rs0_data = w_hit_rs0 ? i_wd : r_regs[i_rs0_idx];
  assign o_rs1_data = w_hit_rs1 ? i_wd : r_regs[i_rs1_idx];
  assign o_rd_data  = w_hit_rd  ? i_wd : r_regs[i_rd_idx];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-issue stage in front of the ALU: bypassed operand read, pending-register
// scoreboard with hazard stall, and a one-entry output register toward the ALU.
module alu_operand_stage
  import nand_cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  ALU_OP                in_op,
  input  logic [REG_IDX_W-1:0] in_rs0,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_use_imm,
  input  logic [IMM_W-1:0]     in_imm,

  alu_input_ifc.out            out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_IDX_W-1:0] out_rd,

  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]    wb_data
);

  issue_t w_issue;
  assign w_issue = '{op: in_op, rs0: in_rs0, rs1: in_rs1, rd: in_rd,
                     use_imm: in_use_imm, imm: in_imm};

  logic [DATA_W-1:0] w_rs0_val, w_rs1_val, w_rd_val;

  nand_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_rs0_idx  (w_issue.rs0),
    .i_rs1_idx  (w_issue.rs1),
    .i_rd_idx   (w_issue.rd),
    .o_rs0_data (w_rs0_val),
    .o_rs1_data (w_rs1_val),
    .o_rd_data  (w_rd_val),
    .i_we       (wb_valid),
    .i_wa       (wb_rd),
    .i_wd       (wb_data)
  );

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;

  // A pending register only blocks if this cycle's writeback is not resolving it.
  function automatic logic blocks(input logic [NUM_REGS-1:0] pend,
                                  input logic [REG_IDX_W-1:0] idx,
                                  input logic wv,
                                  input logic [REG_IDX_W-1:0] wrd);
    return pend[idx] && !(wv && (wrd == idx));
  endfunction

  logic w_use_rs0, w_use_rs1, w_hazard, w_accept;

  always_comb begin
    w_use_rs0 = 1'b0;
    w_use_rs1 = 1'b0;
    if (w_issue.op == ALU_CP) begin
      w_use_rs0 = 1'b1;
    end else if (is_binary(w_issue.op)) begin
      w_use_rs0 = 1'b1;
      w_use_rs1 = !w_issue.use_imm;
    end
  end

  // The rd check covers both WAW and the read-modify source of LI.
  assign w_hazard = (w_use_rs0 && blocks(r_pending, w_issue.rs0, wb_valid, wb_rd)) ||
                    (w_use_rs1 && blocks(r_pending, w_issue.rs1, wb_valid, wb_rd)) ||
                    blocks(r_pending, w_issue.rd, wb_valid, wb_rd);

  assign in_ready = !w_hazard && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  logic [DATA_W-1:0] w_op0, w_op1;

  always_comb begin
    w_op0 = '0;
    w_op1 = '0;
    case (w_issue.op)
      ALU_CL: begin
        w_op0 = '0;
        w_op1 = '0;
      end
      ALU_CP: begin
        w_op0 = w_rs0_val;
        w_op1 = '0;
      end
      ALU_LI: begin
        w_op0 = w_rd_val;
        w_op1 = zext_imm(w_issue.imm);
      end
      default: begin
        w_op0 = w_rs0_val;
        w_op1 = w_issue.use_imm ? zext_imm(w_issue.imm) : w_rs1_val;
      end
    endcase
  end

  // Clear first, then set, so a same-index set wins over the writeback clear.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_valid) w_pending_nxt[wb_rd] = 1'b0;
    if (w_accept) w_pending_nxt[w_issue.rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_op0, r_op1;
  ALU_OP                r_alu_op;
  logic [REG_IDX_W-1:0] r_out_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_op0       <= '0;
      r_op1       <= '0;
      r_alu_op    <= ALU_CL;
      r_out_rd    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_op0       <= w_op0;
      r_op1       <= w_op1;
      r_alu_op    <= w_issue.op;
      r_out_rd    <= w_issue.rd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_rd     = r_out_rd;
  assign out.op0    = r_op0;
  assign out.op1    = r_op1;
  assign out.alu_op = r_alu_op;

endmodule
